// File: rtl/cipher_mode_engine.sv
// Block-cipher mode controller (ECB/CBC/CFB/OFB/CTR) between a valid/ready stream
// and an external block-cipher core with a start/done handshake.
module cipher_mode_engine #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned CTR_W   = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic               decrypt,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               iv_load,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic               core_dec,
    output logic [BLOCK_W-1:0] core_din,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_dout,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   blk_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUTPUT} state_e;
    typedef enum logic [2:0] {
        MODE_ECB = 3'd0,
        MODE_CBC = 3'd1,
        MODE_CFB = 3'd2,
        MODE_OFB = 3'd3,
        MODE_CTR = 3'd4
    } mode_e;

    state_e             state, stateNext;
    logic [BLOCK_W-1:0] chainReg, ctrReg, dataReg, resReg;
    logic [BLOCK_W-1:0] coreIn, result, chainNext, ctrNext;
    logic [2:0]         modeReg;
    logic               decReg, decEff, errReg, accept, modeBad;
    logic [CNT_W-1:0]   blkCount;

    assign in_ready   = (state == ST_IDLE) & ~iv_load;
    assign accept     = in_valid & in_ready;
    assign modeBad    = mode > 3'd4;
    assign busy       = state != ST_IDLE;
    assign core_start = state == ST_ISSUE;
    assign core_dec   = (state == ST_ISSUE) & decEff;
    assign core_din   = (state == ST_ISSUE) ? coreIn : '0;
    assign out_valid  = state == ST_OUTPUT;
    assign out_data   = (state == ST_OUTPUT) ? resReg : '0;
    assign err        = errReg;
    assign blk_count  = blkCount;

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (accept) stateNext = modeBad ? ST_OUTPUT : ST_ISSUE;
            ST_ISSUE:  stateNext = ST_WAIT;
            ST_WAIT:   if (core_done) stateNext = ST_OUTPUT;
            ST_OUTPUT: if (out_ready) stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Core input, result and chaining state all derive from the latched mode/direction.
    always_comb begin
        coreIn    = '0;
        result    = core_dout;
        chainNext = chainReg;
        ctrNext   = ctrReg;
        decEff    = 1'b0;
        case (modeReg)
            MODE_ECB: begin
                coreIn = dataReg;
                decEff = decReg;
            end
            MODE_CBC: begin
                decEff = decReg;
                if (decReg) begin
                    coreIn    = dataReg;
                    result    = core_dout ^ chainReg;
                    chainNext = dataReg;
                end else begin
                    coreIn    = dataReg ^ chainReg;
                    chainNext = core_dout;
                end
            end
            MODE_CFB: begin
                coreIn    = chainReg;
                result    = core_dout ^ dataReg;
                chainNext = decReg ? dataReg : (core_dout ^ dataReg);
            end
            MODE_OFB: begin
                coreIn    = chainReg;
                result    = core_dout ^ dataReg;
                chainNext = core_dout;
            end
            MODE_CTR: begin
                coreIn  = ctrReg;
                result  = core_dout ^ dataReg;
                ctrNext[CTR_W-1:0] = ctrReg[CTR_W-1:0] + CTR_W'(1);
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chainReg <= '0;
            ctrReg   <= '0;
            dataReg  <= '0;
            resReg   <= '0;
            modeReg  <= '0;
            decReg   <= 1'b0;
            errReg   <= 1'b0;
            blkCount <= '0;
        end else begin
            if (state == ST_IDLE && iv_load) begin
                chainReg <= iv;
                ctrReg   <= iv;
            end
            if (accept) begin
                dataReg <= in_data;
                modeReg <= mode;
                decReg  <= decrypt;
                if (modeBad) begin
                    resReg <= '0;
                    errReg <= 1'b1;
                end
            end
            if (state == ST_WAIT && core_done) begin
                resReg   <= result;
                chainReg <= chainNext;
                ctrReg   <= ctrNext;
            end
            if (state == ST_OUTPUT && out_ready) blkCount <= blkCount + CNT_W'(1);
        end
    end

endmodule

// File: doc/cipher_mode_engine.md
Name: cipher_mode_engine

Overview:
- Parametrised block-cipher mode controller. Sits between the coprocessor datapath and an external block-cipher core (AES core with key already expanded).
- Implements ECB/CBC/CFB/OFB/CTR chaining with a valid/ready streaming interface, including output backpressure.
- Generalises the existing fixed-128-bit AES wrapper to any block width, a configurable CTR increment field, sticky error reporting and a processed-block counter.

Parameters:
- BLOCK_W, 128: cipher block width in bits (core data width).
- CTR_W, 32: width of the low counter field incremented in CTR mode (1..BLOCK_W).
- CNT_W, 16: width of the processed-block counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  3  0=ECB 1=CBC 2=CFB 3=OFB 4=CTR; 5-7 invalid.
- decrypt  in  1  0=encrypt, 1=decrypt.
- iv  in  BLOCK_W  IV or initial counter.
- iv_load  in  1  pulse: chain_reg<=iv and ctr_reg<=iv.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine accepts a block.
- in_data  in  BLOCK_W  plaintext or ciphertext block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  BLOCK_W  result block.
- core_start  out  1  one-cycle start pulse to the core.
- core_dec  out  1  core direction.
- core_din  out  BLOCK_W  core input block.
- core_done  in  1  one-cycle pulse when core_dout is valid.
- core_dout  in  BLOCK_W  core output block.
- busy  out  1  state != IDLE.
- err  out  1  sticky invalid-mode flag.
- blk_count  out  CNT_W  number of blocks delivered; wraps.

Behaviour:
- Reset:
  - state=IDLE.
  - chain_reg, ctr_reg, data_reg and res_reg are 0.
  - All outputs are 0, except in_ready=1 when iv_load=0.
  - Reset mid-operation abandons the block; any late core_done is ignored.
- in_ready = (state==IDLE) & !iv_load.
- iv_load is honoured only in IDLE; it is ignored in all other states.
- Accept:
  - Occurs when in_valid & in_ready at cycle T.
  - Latches in_data, mode and decrypt; later changes to mode and decrypt have no effect on that block.
  - Next state is ISSUE, or OUTPUT with res=0 and err<=1 if mode>4.
- ISSUE (T+1):
  - core_start=1 for exactly one cycle, then WAIT.
  - core_dec = decrypt for ECB/CBC; 0 for all other modes.
  - core_din:
    - ECB: data.
    - CBC encrypt: data^chain.
    - CBC decrypt: data.
    - CFB/OFB: chain.
    - CTR: ctr.
- WAIT: hold until core_done. On core_done (cycle D), res_reg <= result, then OUTPUT.
  - ECB: result = dout.
  - CBC encrypt: result = dout. CBC decrypt: result = dout^chain.
  - CFB/OFB/CTR: result = dout^data.
- Chain update at D:
  - CBC/CFB encrypt: chain <= result.
  - CBC/CFB decrypt: chain <= data.
  - OFB: chain <= dout.
  - CTR: ctr[CTR_W-1:0] += 1, modulo 2^CTR_W; upper bits unchanged.
  - ECB: no change.
- OUTPUT:
  - out_valid=1 and out_data=res_reg, held stable until out_ready.
  - On handshake: blk_count+=1 (wraps), then IDLE.
  - out_data=0 whenever out_valid=0.
- Latency: out_valid first asserts at D+1. Back-to-back throughput is one block per (core latency + 3) cycles.
- core_done outside WAIT is ignored.
- err clears only on reset.

Test Plan:
- All vectors use AES-128 key 2b7e151628aed2a6abf7158809cf4f3c.
- ECB encrypt: in 6bc1bee22e409f96e93d7e117393172a -> out 3ad77bb40d7a3660a89ecaf32466ef97. Also check blk_count=1 and core_start high exactly one cycle.
- CBC encrypt chaining:
  - iv_load 000102030405060708090a0b0c0d0e0f.
  - Block 6bc1...172a -> 7649abac8119b246cee98e9b12e9197d.
  - Block ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
  - Decrypting both ciphertexts after reloading the IV returns the plaintexts.
- OFB and CFB encrypt: same IV, block 6bc1...172a -> 3b3fd92eb72dad20333449f8e83cfb4a in each mode.
- CTR:
  - iv_load f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block 6bc1...172a -> 874d6191b620e3261bef6864990db6ce.
  - With CTR_W=8, the next core_din is f0f1...fdfe00; upper bytes are unchanged.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: out_data stable, in_ready=0, blk_count unchanged.
  - Assert reset while in WAIT: next cycle busy=0, out_valid=0, chain=0; a subsequent core_done produces no output.
- Invalid mode and iv_load collision:
  - mode=6 block -> out_data=0 and err=1; err stays set after later valid blocks.
  - iv_load with in_valid high in IDLE -> in_ready=0 that cycle; the block is accepted next cycle using the new IV.
